// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths and constants for the ID/EX pipeline register slice.
package id_ex_stage_reg_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_CMD_W  = 4;

    localparam logic [DEF_CMD_W-1:0] EXE_NOP = '0;

    // Bubble counter field: width and saturation ceiling.
    localparam int                  BUBBLE_W   = 16;
    localparam logic [BUBBLE_W-1:0] BUBBLE_MAX = '1;
endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard comparator: ID instruction reads the register an EX-stage load writes.
module load_use_detect #(
    parameter int REG_W = id_ex_stage_reg_pkg::DEF_REG_W
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_uses_src2,
    input  logic             ex_valid,
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_dest,
    output logic             hazard
);
    logic src1_hit;
    logic src2_hit;

    always_comb begin
        src1_hit = (ex_dest == id_src1);
        src2_hit = id_uses_src2 && (ex_dest == id_src2);
        hazard   = id_valid && ex_valid && ex_memRead && (ex_dest != '0) && (src1_hit || src2_hit);
    end
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, WB bypass and bubble counter.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int CMD_W  = DEF_CMD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_src1,
    input  logic [REG_W-1:0]    id_src2,
    input  logic                id_uses_src2,
    input  logic [REG_W-1:0]    id_dest,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [DATA_W-1:0]   id_pc,
    input  logic                id_wbEn,
    input  logic                id_memRead,
    input  logic                id_memWrite,
    input  logic [CMD_W-1:0]    id_exeCmd,
    input  logic                wb_en,
    input  logic [REG_W-1:0]    wb_dest,
    input  logic [DATA_W-1:0]   wb_val,
    output logic                hazard_stall,
    output logic                ex_valid,
    output logic                ex_wbEn,
    output logic                ex_memRead,
    output logic                ex_memWrite,
    output logic [CMD_W-1:0]    ex_exeCmd,
    output logic [REG_W-1:0]    ex_dest,
    output logic [REG_W-1:0]    ex_src1,
    output logic [REG_W-1:0]    ex_src2,
    output logic [DATA_W-1:0]   ex_val1,
    output logic [DATA_W-1:0]   ex_val2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [DATA_W-1:0]   ex_pc,
    output logic [BUBBLE_W-1:0] bubble_count
);
    logic              hazard;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src2 (id_uses_src2),
        .ex_valid     (ex_valid),
        .ex_memRead   (ex_memRead),
        .ex_dest      (ex_dest),
        .hazard       (hazard)
    );

    // A taken branch kills the dependent instruction, so no stall is needed.
    assign hazard_stall = hazard && !flush;

    // WB bypass covers the register file writing and being read in the same cycle.
    always_comb begin
        op1 = id_reg1;
        if (id_src1 == '0)
            op1 = '0;
        else if (wb_en && (wb_dest == id_src1))
            op1 = wb_val;

        op2 = id_reg2;
        if (id_src2 == '0)
            op2 = '0;
        else if (wb_en && (wb_dest == id_src2))
            op2 = wb_val;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_wbEn      <= 1'b0;
            ex_memRead   <= 1'b0;
            ex_memWrite  <= 1'b0;
            ex_exeCmd    <= CMD_W'(EXE_NOP);
            ex_dest      <= '0;
            ex_src1      <= '0;
            ex_src2      <= '0;
            ex_val1      <= '0;
            ex_val2      <= '0;
            ex_imm       <= '0;
            ex_pc        <= '0;
            bubble_count <= '0;
        end else if (freeze) begin
            // hold everything
        end else if (flush || hazard) begin
            ex_valid    <= 1'b0;
            ex_wbEn     <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_exeCmd   <= CMD_W'(EXE_NOP);
            ex_dest     <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_val1     <= '0;
            ex_val2     <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            if (!flush && (bubble_count != BUBBLE_MAX))
                bubble_count <= bubble_count + 1'b1;
        end else begin
            ex_valid    <= id_valid;
            ex_wbEn     <= id_valid && id_wbEn;
            ex_memRead  <= id_valid && id_memRead;
            ex_memWrite <= id_valid && id_memWrite;
            ex_exeCmd   <= id_valid ? id_exeCmd : CMD_W'(EXE_NOP);
            ex_dest     <= id_dest;
            ex_src1     <= id_src1;
            ex_src2     <= id_src2;
            ex_val1     <= op1;
            ex_val2     <= op2;
            ex_imm      <= id_imm;
            ex_pc       <= id_pc;
        end
    end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: reference model pushes expected EX state per edge.
module tb_id_ex_stage_reg;
    logic        clk;
    logic        rst, freeze, flush;
    logic        id_valid, id_uses_src2;
    logic [4:0]  id_src1, id_src2, id_dest;
    logic [31:0] id_reg1, id_reg2, id_imm, id_pc;
    logic        id_wbEn, id_memRead, id_memWrite;
    logic [3:0]  id_exeCmd;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_val;
    logic        hazard_stall;
    logic        ex_valid, ex_wbEn, ex_memRead, ex_memWrite;
    logic [3:0]  ex_exeCmd;
    logic [4:0]  ex_dest, ex_src1, ex_src2;
    logic [31:0] ex_val1, ex_val2, ex_imm, ex_pc;
    logic [15:0] bubble_count;

    typedef struct packed {
        logic        valid, wbEn, memRead, memWrite;
        logic [3:0]  cmd;
        logic [4:0]  dest, src1, src2;
        logic [31:0] val1, val2, imm, pc;
        logic [15:0] bc;
    } exp_t;

    exp_t m;
    exp_t q[$];
    int   checks;
    int   failures;
    bit   primed;

    id_ex_stage_reg #(.DATA_W(32), .REG_W(5), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src2(id_uses_src2), .id_dest(id_dest),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm), .id_pc(id_pc),
        .id_wbEn(id_wbEn), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_exeCmd(id_exeCmd), .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_wbEn(ex_wbEn),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_exeCmd(ex_exeCmd),
        .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] opsel(input logic [4:0] src, input logic [31:0] rf);
        if (src == 5'd0) return 32'd0;
        if (wb_en && wb_dest == src) return wb_val;
        return rf;
    endfunction

    task automatic idle();
        rst = 1; freeze = 0; flush = 0;
        id_valid = 0; id_uses_src2 = 0; id_src1 = 0; id_src2 = 0; id_dest = 0;
        id_reg1 = 0; id_reg2 = 0; id_imm = 0; id_pc = 0;
        id_wbEn = 0; id_memRead = 0; id_memWrite = 0; id_exeCmd = 0;
        wb_en = 0; wb_dest = 0; wb_val = 0;
    endtask

    task automatic instr(input logic [4:0] s1, input logic [4:0] s2, input logic us2,
                         input logic [4:0] d, input logic mr, input logic [3:0] cmd);
        id_valid = 1; id_src1 = s1; id_src2 = s2; id_uses_src2 = us2; id_dest = d;
        id_memRead = mr; id_wbEn = 1; id_memWrite = 0; id_exeCmd = cmd;
        id_reg1 = 32'h100 + 32'(s1); id_reg2 = 32'h200 + 32'(s2);
        id_imm = 32'h40; id_pc = id_pc + 32'd4;
    endtask

    // One clock: check stall before the edge, predict the edge, compare after it.
    task automatic step();
        exp_t n, e;
        logic hz;
        #1;
        hz = id_valid && m.valid && m.memRead && (m.dest != 0) &&
             ((m.dest == id_src1) || (id_uses_src2 && m.dest == id_src2));
        if (primed) check("hazard_stall", 64'(hazard_stall), 64'(hz && !flush));
        n = m;
        if (!rst) n = '0;
        else if (freeze) n = m;
        else if (flush || hz) begin
            n = '0;
            n.bc = (!flush && m.bc != 16'hFFFF) ? m.bc + 16'd1 : m.bc;
        end else begin
            n.valid = id_valid; n.wbEn = id_valid & id_wbEn;
            n.memRead = id_valid & id_memRead; n.memWrite = id_valid & id_memWrite;
            n.cmd = id_valid ? id_exeCmd : 4'd0;
            n.dest = id_dest; n.src1 = id_src1; n.src2 = id_src2;
            n.val1 = opsel(id_src1, id_reg1); n.val2 = opsel(id_src2, id_reg2);
            n.imm = id_imm; n.pc = id_pc;
        end
        q.push_back(n);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("ex_valid", 64'(ex_valid), 64'(e.valid));
        check("ex_wbEn", 64'(ex_wbEn), 64'(e.wbEn));
        check("ex_memRead", 64'(ex_memRead), 64'(e.memRead));
        check("ex_memWrite", 64'(ex_memWrite), 64'(e.memWrite));
        check("ex_exeCmd", 64'(ex_exeCmd), 64'(e.cmd));
        check("ex_dest", 64'(ex_dest), 64'(e.dest));
        check("ex_src1", 64'(ex_src1), 64'(e.src1));
        check("ex_src2", 64'(ex_src2), 64'(e.src2));
        check("ex_val1", 64'(ex_val1), 64'(e.val1));
        check("ex_val2", 64'(ex_val2), 64'(e.val2));
        check("ex_imm", 64'(ex_imm), 64'(e.imm));
        check("ex_pc", 64'(ex_pc), 64'(e.pc));
        check("bubble_count", 64'(bubble_count), 64'(e.bc));
        m = e;
        primed = 1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0; primed = 0; m = '0;
        idle();
        @(negedge clk);

        // reset with a live instruction in ID
        rst = 0; instr(5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 4'd5);
        step(); step();
        check("rst_stall", 64'(hazard_stall), 64'd0);
        check("rst_count", 64'(bubble_count), 64'd0);

        // plain capture
        idle(); instr(5'd3, 5'd0, 1'b0, 5'd4, 1'b0, 4'd2);
        id_reg1 = 32'h11; id_imm = 32'h20;
        step();
        check("cap_val1", 64'(ex_val1), 64'h11);
        check("cap_imm", 64'(ex_imm), 64'h20);
        check("cap_cmd", 64'(ex_exeCmd), 64'd2);

        // load-use: lw r5, then add using r5 as src2
        instr(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 4'd0); step();
        instr(5'd2, 5'd5, 1'b1, 5'd6, 1'b0, 4'd1);
        step();
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_count", 64'(bubble_count), 64'd1);
        step();
        check("lu_capture", 64'(ex_valid), 64'd1);

        // no false hazard: ex_dest == 0, and src2 not used
        instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 4'd0); step();
        instr(5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 4'd1); step();
        instr(5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 4'd0); step();
        instr(5'd1, 5'd8, 1'b0, 5'd9, 1'b0, 4'd1); step();

        // write-back bypass
        instr(5'd7, 5'd7, 1'b1, 5'd3, 1'b0, 4'd3);
        id_reg1 = 32'h2; wb_en = 1; wb_dest = 5'd7; wb_val = 32'hABCD;
        step();
        check("byp_val1", 64'(ex_val1), 64'hABCD);
        instr(5'd0, 5'd7, 1'b1, 5'd3, 1'b0, 4'd3); id_reg1 = 32'h2;
        step();
        check("byp_zero", 64'(ex_val1), 64'd0);
        wb_en = 0;

        // freeze during load-use, then release
        instr(5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 4'd0); step();
        instr(5'd9, 5'd0, 1'b0, 5'd10, 1'b0, 4'd1);
        freeze = 1; step(); step();
        freeze = 0; step(); step();

        // flush with hazard: bubble, no count
        instr(5'd1, 5'd0, 1'b0, 5'd10, 1'b1, 4'd0); step();
        instr(5'd10, 5'd0, 1'b0, 5'd11, 1'b0, 4'd1);
        flush = 1; step();
        flush = 0; step();

        // freeze and flush together: freeze wins
        instr(5'd1, 5'd0, 1'b0, 5'd12, 1'b1, 4'd0); step();
        instr(5'd12, 5'd0, 1'b0, 5'd13, 1'b0, 4'd1);
        freeze = 1; flush = 1; step();
        freeze = 0; step();
        flush = 0; step();

        // reset mid-hazard
        instr(5'd1, 5'd0, 1'b0, 5'd11, 1'b1, 4'd0); step();
        instr(5'd11, 5'd0, 1'b0, 5'd2, 1'b0, 4'd1);
        rst = 0; step();
        rst = 1; step();

        // random traffic over a tiny register space to provoke hazards
        for (int i = 0; i < 300; i++) begin
            instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 4'($urandom));
            id_valid = ($urandom_range(0, 7) != 0);
            id_memWrite = 1'($urandom);
            id_reg1 = $urandom; id_reg2 = $urandom; id_imm = $urandom;
            wb_en = 1'($urandom); wb_dest = 5'($urandom_range(0, 3)); wb_val = $urandom;
            freeze = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) != 0);
            step();
        end

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the 5-stage MIPS core; sits directly downstream of the register file and decode logic, capturing operands and control for the EX stage. Detects load-use hazards against the instruction currently in EX, inserts exactly one bubble, and requests an upstream stall. Also applies a write-back bypass so operands written by WB in the capture cycle are never lost, and counts inserted bubbles for performance monitoring.

## Interface
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register address width
- CMD_W, 4, EX command width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- freeze  in  1  hold all EX-side state (downstream memory stall)
- flush  in  1  kill the instruction being captured (taken branch)
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  REG_W  source register addresses
- id_uses_src2  in  1  instruction reads src2 (R-type, store, branch)
- id_dest  in  REG_W  destination register
- id_reg1, id_reg2  in  DATA_W  register file read data
- id_imm, id_pc  in  DATA_W  sign-extended immediate, PC+4
- id_wbEn, id_memRead, id_memWrite  in  1  control bits
- id_exeCmd  in  CMD_W  ALU command
- wb_en  in  1; wb_dest  in  REG_W; wb_val  in  DATA_W  write-back port, same signals driven to the register file
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid, ex_wbEn, ex_memRead, ex_memWrite  out  1  registered
- ex_exeCmd  out  CMD_W; ex_dest, ex_src1, ex_src2  out  REG_W  registered
- ex_val1, ex_val2, ex_imm, ex_pc  out  DATA_W  registered
- bubble_count  out  16  saturating count of inserted load-use bubbles

## Operation
- hazard = id_valid & ex_valid & ex_memRead & (ex_dest != 0) & ((ex_dest == id_src1) | (id_uses_src2 & ex_dest == id_src2)).
- hazard_stall = hazard & ~flush.
- Per-edge priority: rst low > freeze > flush > hazard > capture.
- rst low: every output register cleared to 0 (ex_valid 0, exeCmd NOP = 0), bubble_count 0.
- freeze: all registers and bubble_count hold; hazard_stall still reported.
- flush: load bubble (ex_valid, ex_wbEn, ex_memRead, ex_memWrite, ex_exeCmd = 0; data fields 0); bubble_count unchanged.
- hazard: load bubble as above; bubble_count += 1, saturating at 16'hFFFF.
- capture: all ex_* take id_* with ex_valid = id_valid; control bits forced 0 when id_valid = 0.
- Operand select for ex_val1 (ex_val2 analogous with src2/reg2): src == 0 -> 0; else wb_en & wb_dest == src -> wb_val; else id_reg.
- Bubble zeroes memRead, so hazard deasserts the next cycle: at most one bubble per load-use pair.

## Timing
- Capture latency 1 cycle: ID inputs at edge N appear on ex_* after edge N.
- hazard_stall depends only on current ex_* registers and ID inputs; no internal combinational path from wb_* to it.
- Reset mid-hazard: bubble_count and ex_* cleared at that edge; hazard_stall low once ex_valid is 0.
- Simultaneous flush and hazard: flush wins, hazard_stall low, no count.
- Simultaneous freeze and flush: freeze wins; upstream must keep flush asserted until freeze drops.

## Structure
- Shared package: DATA_W, REG_W, CMD_W defaults, EXE_NOP = 0, bubble field constants.
- One sub-module: load_use_detect (pure comparator producing hazard); the pipeline register, bypass muxes and counter stay in the top.

## Test plan
- Reset: rst = 0 for 2 cycles with id_valid = 1 -> all ex_* = 0, bubble_count = 0, hazard_stall = 0.
- Plain capture: id_src1 = 3, id_reg1 = 0x11, id_imm = 0x20, id_exeCmd = 2 -> next cycle ex_val1 = 0x11, ex_imm = 0x20, ex_exeCmd = 2, ex_valid = 1.
- Load-use: EX holds lw dest 5; ID add src2 = 5, id_uses_src2 = 1 -> hazard_stall = 1 one cycle, ex_valid = 0 next, bubble_count = 1, add captured cycle after.
- No false hazard: ex_dest = 0 with memRead, or id_uses_src2 = 0 with ex_dest == id_src2 -> hazard_stall = 0.
- Bypass: wb_en = 1, wb_dest = 7, wb_val = 0xABCD, id_src1 = 7, id_reg1 = 0x2 -> ex_val1 = 0xABCD; id_src1 = 0 -> ex_val1 = 0.
- Freeze/flush: freeze = 1 during load-use -> ex_* and bubble_count hold; flush = 1 with hazard -> bubble, hazard_stall = 0, count unchanged.
